// File: rtl/store_alignment_pkg.sv
// Shared types and constants for the store alignment path.
// The misaligned-split build option is STORE_MISALIGNED_SPLIT_EN.
package store_alignment_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] FUNCT3_SB = 3'b000;
   localparam logic [2:0] FUNCT3_SH = 3'b001;
   localparam logic [2:0] FUNCT3_SW = 3'b010;

   // Lane span of a shifted store: two words when splitting, otherwise one.
`ifdef STORE_MISALIGNED_SPLIT_EN
   localparam int LANE_BYTES = 8;
`else
   localparam int LANE_BYTES = 4;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } st_e;

   // Unshifted byte mask of a store; zero marks an illegal funct3.
   function automatic logic [3:0] width_mask(input logic [2:0] funct3);
      logic [3:0] m;
      case (funct3)
         FUNCT3_SB: m = 4'b0001;
         FUNCT3_SH: m = 4'b0011;
         FUNCT3_SW: m = 4'b1111;
         default:   m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane mask / data shifter for one store request.
// Upper-word lanes exist only when STORE_MISALIGNED_SPLIT_EN is defined.
module store_lane_gen
   import store_alignment_pkg::*;
(
   input  logic [2:0]                funct3,
   input  logic [1:0]                sft,
   input  logic [XLEN-1:0]           data,
   output logic [LANE_BYTES-1:0]     mask8,
   output logic [8*LANE_BYTES-1:0]   wide64,
   output logic                      misaligned,
   output logic                      illegal
);

   logic [3:0]      wmask;
   logic [XLEN-1:0] data_m;

   assign wmask  = width_mask(funct3);
   assign data_m = data & {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

   always_comb begin
      illegal    = (wmask == 4'b0000);
      mask8      = LANE_BYTES'(wmask) << sft;
      wide64     = (8*LANE_BYTES)'(data_m) << {sft, 3'b000};
      misaligned = ((funct3 == FUNCT3_SH) && (sft == 2'd3)) ||
                   ((funct3 == FUNCT3_SW) && (sft != 2'd0));
   end

endmodule

// File: rtl/store_alignment.sv
// Store alignment: turns byte-addressed stores into word writes with byte enables.
// STORE_MISALIGNED_SPLIT_EN enables two-beat issue of word-crossing stores.
//
// state    | meaning
// ST_IDLE  | no beat pending
// ST_BEAT0 | first (or only) beat presented on mem_*
// ST_BEAT1 | second beat of a split store presented on mem_*
module store_alignment
   import store_alignment_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [2:0]        st_funct3,
   input  logic [XLEN-1:0]   st_adr,
   input  logic [XLEN-1:0]   st_data,
   output logic              st_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [XLEN-3:0]   mem_adr,
   output logic [3:0]        mem_wea,
   output logic [XLEN-1:0]   mem_din
);

   st_e               state_q, state_d;
   logic              mem_valid_q, mem_valid_d;
   logic [XLEN-3:0]   mem_adr_q, mem_adr_d;
   logic [3:0]        mem_wea_q, mem_wea_d;
   logic [XLEN-1:0]   mem_din_q, mem_din_d;
   logic              st_err_q, st_err_d;

   logic [LANE_BYTES-1:0]   mask8;
   logic [8*LANE_BYTES-1:0] wide64;
   logic                    misaligned;
   logic                    illegal;
   logic                    last_beat;
   logic                    accept;
   logic                    drop;

   store_lane_gen u_lane_gen (
      .funct3     (st_funct3),
      .sft        (st_adr[1:0]),
      .data       (st_data),
      .mask8      (mask8),
      .wide64     (wide64),
      .misaligned (misaligned),
      .illegal    (illegal)
   );

`ifdef STORE_MISALIGNED_SPLIT_EN
   logic              split_q, split_d;
   logic [3:0]        hi_wea_q, hi_wea_d;
   logic [XLEN-1:0]   hi_din_q, hi_din_d;

   assign last_beat = (state_q == ST_BEAT1) || ((state_q == ST_BEAT0) && !split_q);
   assign drop      = illegal;
`else
   assign last_beat = (state_q == ST_BEAT0);
   assign drop      = illegal || misaligned;
`endif

   assign st_ready  = (state_q == ST_IDLE) || (mem_ready && last_beat);
   assign accept    = st_valid && st_ready;

   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_adr_d   = mem_adr_q;
      mem_wea_d   = mem_wea_q;
      mem_din_d   = mem_din_q;
      st_err_d    = accept && drop;
`ifdef STORE_MISALIGNED_SPLIT_EN
      split_d     = split_q;
      hi_wea_d    = hi_wea_q;
      hi_din_d    = hi_din_q;
`endif

      if (mem_valid_q && mem_ready) begin
         state_d     = ST_IDLE;
         mem_valid_d = 1'b0;
         mem_wea_d   = 4'b0000;
`ifdef STORE_MISALIGNED_SPLIT_EN
         if ((state_q == ST_BEAT0) && split_q) begin
            state_d     = ST_BEAT1;
            mem_valid_d = 1'b1;
            mem_adr_d   = mem_adr_q + 1'b1;
            mem_wea_d   = hi_wea_q;
            mem_din_d   = hi_din_q;
            split_d     = 1'b0;
         end
`endif
      end

      // A new request only wins here when the current beat is the last one.
      if (accept && !drop) begin
         state_d     = ST_BEAT0;
         mem_valid_d = 1'b1;
         mem_adr_d   = st_adr[XLEN-1:2];
         mem_wea_d   = mask8[3:0];
         mem_din_d   = wide64[31:0];
`ifdef STORE_MISALIGNED_SPLIT_EN
         split_d     = misaligned;
         hi_wea_d    = mask8[7:4];
         hi_din_d    = wide64[63:32];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mem_valid_q <= 1'b0;
         mem_adr_q   <= '0;
         mem_wea_q   <= 4'b0000;
         mem_din_q   <= '0;
         st_err_q    <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
         split_q     <= 1'b0;
         hi_wea_q    <= 4'b0000;
         hi_din_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_adr_q   <= mem_adr_d;
         mem_wea_q   <= mem_wea_d;
         mem_din_q   <= mem_din_d;
         st_err_q    <= st_err_d;
`ifdef STORE_MISALIGNED_SPLIT_EN
         split_q     <= split_d;
         hi_wea_q    <= hi_wea_d;
         hi_din_q    <= hi_din_d;
`endif
      end
   end

   assign mem_valid = mem_valid_q;
   assign mem_adr   = mem_adr_q;
   assign mem_wea   = mem_wea_q;
   assign mem_din   = mem_din_q;
   assign st_err    = st_err_q;

endmodule

// File: tb/tb_store_alignment.sv
// Scoreboard bench for store_alignment; expectations follow STORE_MISALIGNED_SPLIT_EN.
module tb_store_alignment;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [2:0]  st_funct3;
   logic [31:0] st_adr;
   logic [31:0] st_data;
   logic        st_err;
   logic        mem_valid;
   logic        mem_ready;
   logic [29:0] mem_adr;
   logic [3:0]  mem_wea;
   logic [31:0] mem_din;

   always #5 clk = ~clk;

   store_alignment dut (
      .clk       (clk),
      .rst       (rst),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_funct3 (st_funct3),
      .st_adr    (st_adr),
      .st_data   (st_data),
      .st_err    (st_err),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_adr   (mem_adr),
      .mem_wea   (mem_wea),
      .mem_din   (mem_din)
   );

   typedef struct {
      bit          is_err;
      logic [29:0] adr;
      logic [3:0]  wea;
      logic [31:0] din;
      bit          last;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   // Reference: place each stored byte in lane (sft+i); lanes 4..7 belong to the next word.
   function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int   width;
      int   sft;
      int   lane;
      exp_t b0, b1, e;
      width = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      sft   = int'(a[1:0]);
      e.is_err = 1'b1; e.adr = '0; e.wea = '0; e.din = '0; e.last = 1'b1;
      if (width == 0) begin
         expq.push_back(e);
         return;
      end
`ifndef STORE_MISALIGNED_SPLIT_EN
      if (sft + width > 4) begin
         expq.push_back(e);
         return;
      end
`endif
      b0.is_err = 1'b0; b0.adr = a[31:2];         b0.wea = '0; b0.din = '0; b0.last = 1'b0;
      b1.is_err = 1'b0; b1.adr = a[31:2] + 30'd1; b1.wea = '0; b1.din = '0; b1.last = 1'b1;
      for (int i = 0; i < width; i++) begin
         lane = sft + i;
         if (lane < 4) begin
            b0.wea[lane] = 1'b1;
            b0.din[8*lane +: 8] = d[8*i +: 8];
         end else begin
            b1.wea[lane-4] = 1'b1;
            b1.din[8*(lane-4) +: 8] = d[8*i +: 8];
         end
      end
      if (sft + width > 4) begin
         expq.push_back(b0);
         expq.push_back(b1);
      end else begin
         b0.last = 1'b1;
         expq.push_back(b0);
      end
   endfunction

   // Caller is just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int n   = 0;
      bit acc = 1'b0;
      st_valid  = 1'b1;
      st_funct3 = f3;
      st_adr    = a;
      st_data   = d;
      while (!acc && n < 20) begin
         samp();
         if (st_ready) begin
            acc = 1'b1;
            model(f3, a, d);
         end
         step();
         n++;
      end
      st_valid = 1'b0;
      chk("issue_accepted", 64'(acc), 64'd1);
   endtask

   // Monitor: handshake-driven scoreboard pops plus hold-stability and ready checks.
   initial begin
      exp_t        e;
      bit          prev_stall;
      logic [29:0] p_adr;
      logic [3:0]  p_wea;
      logic [31:0] p_din;
      logic [31:0] lm;
      prev_stall = 1'b0;
      p_adr = '0; p_wea = '0; p_din = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            chk("hold_valid", 64'(mem_valid), 64'd1);
            chk("hold_adr",   64'(mem_adr),   64'(p_adr));
            chk("hold_wea",   64'(mem_wea),   64'(p_wea));
            chk("hold_din",   64'(mem_din),   64'(p_din));
         end
         if (!mem_valid)
            chk("st_ready_idle", 64'(st_ready), 64'd1);
         else if (expq.size() == 0)
            chk("beat_unexpected", 64'(mem_valid), 64'd0);
         else
            chk("st_ready_busy", 64'(st_ready), 64'(mem_ready && expq[0].last));
         if (st_err) begin
            if (expq.size() == 0)
               chk("err_unexpected", 64'(st_err), 64'd0);
            else begin
               e = expq.pop_front();
               chk("err_expected", 64'(e.is_err), 64'd1);
            end
         end
         if (mem_valid && mem_ready && expq.size() > 0) begin
            e = expq.pop_front();
            chk("beat_kind", 64'(e.is_err), 64'd0);
            chk("beat_adr",  64'(mem_adr), 64'(e.adr));
            chk("beat_wea",  64'(mem_wea), 64'(e.wea));
            lm = {{8{e.wea[3]}}, {8{e.wea[2]}}, {8{e.wea[1]}}, {8{e.wea[0]}}};
            chk("beat_din",  64'(mem_din & lm), 64'(e.din & lm));
         end
         prev_stall = mem_valid && !mem_ready;
         p_adr = mem_adr;
         p_wea = mem_wea;
         p_din = mem_din;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int n;
      rst = 1'b1; st_valid = 1'b0; st_funct3 = '0; st_adr = '0; st_data = '0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      samp();
      chk("rst_st_ready", 64'(st_ready),  64'd1);
      chk("rst_valid",    64'(mem_valid), 64'd0);
      chk("rst_wea",      64'(mem_wea),   64'd0);
      chk("rst_adr",      64'(mem_adr),   64'd0);
      chk("rst_din",      64'(mem_din),   64'd0);
      chk("rst_err",      64'(st_err),    64'd0);
      step();
      rst = 1'b0;
      mem_ready = 1'b1;

      // Aligned SW.
      issue(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
      samp();
      chk("sw_valid", 64'(mem_valid), 64'd1);
      chk("sw_adr",   64'(mem_adr),   64'h40);
      chk("sw_wea",   64'(mem_wea),   64'hF);
      chk("sw_din",   64'(mem_din),   64'hDEAD_BEEF);
      step(); samp();
      chk("sw_done",  64'(mem_valid), 64'd0);
      step();

      // SB to the top lane.
      issue(3'b000, 32'h0000_0203, 32'h1234_56AB);
      samp();
      chk("sb_adr", 64'(mem_adr),        64'h80);
      chk("sb_wea", 64'(mem_wea),        64'h8);
      chk("sb_din", 64'(mem_din[31:24]), 64'hAB);
      step();

      // Word-crossing SW.
      issue(3'b010, 32'h0000_0102, 32'h1122_3344);
      samp();
`ifdef STORE_MISALIGNED_SPLIT_EN
      chk("split_b0_adr", 64'(mem_adr),        64'h40);
      chk("split_b0_wea", 64'(mem_wea),        64'hC);
      chk("split_b0_din", 64'(mem_din[31:16]), 64'h3344);
      step(); samp();
      chk("split_b1_valid", 64'(mem_valid),    64'd1);
      chk("split_b1_adr", 64'(mem_adr),        64'h41);
      chk("split_b1_wea", 64'(mem_wea),        64'h3);
      chk("split_b1_din", 64'(mem_din[15:0]),  64'h1122);
      step(); samp();
      chk("split_done",   64'(mem_valid),      64'd0);
`else
      chk("mis_err",      64'(st_err),    64'd1);
      chk("mis_nobeat",   64'(mem_valid), 64'd0);
      step(); samp();
      chk("mis_err_pulse", 64'(st_err),   64'd0);
`endif
      step();

      // Back-pressure on an SH.
      mem_ready = 1'b0;
      issue(3'b001, 32'h0000_0002, 32'hFFFF_BEEF);
      for (int i = 0; i < 3; i++) begin
         samp();
         chk("bp_valid",    64'(mem_valid),      64'd1);
         chk("bp_wea",      64'(mem_wea),        64'hC);
         chk("bp_din",      64'(mem_din[31:16]), 64'hBEEF);
         chk("bp_st_ready", 64'(st_ready),       64'd0);
         step();
      end
      mem_ready = 1'b1;
      samp();
      chk("bp_release_ready", 64'(st_ready), 64'd1);
      step(); samp();
      chk("bp_done", 64'(mem_valid), 64'd0);
      step();

      // Illegal funct3.
      issue(3'b011, 32'h0000_0040, 32'h0000_0055);
      samp();
      chk("ill_err",    64'(st_err),    64'd1);
      chk("ill_nobeat", 64'(mem_valid), 64'd0);
      step(); samp();
      chk("ill_err_pulse", 64'(st_err),    64'd0);
      chk("ill_nobeat2",   64'(mem_valid), 64'd0);
      step();

      // SH at the very top of the address space.
      issue(3'b001, 32'hFFFF_FFFF, 32'h0000_CAFE);
      samp();
`ifdef STORE_MISALIGNED_SPLIT_EN
      chk("wrap_b0_adr", 64'(mem_adr),        64'h3FFF_FFFF);
      chk("wrap_b0_wea", 64'(mem_wea),        64'h8);
      chk("wrap_b0_din", 64'(mem_din[31:24]), 64'hFE);
      step(); samp();
      chk("wrap_b1_adr", 64'(mem_adr),        64'h0);
      chk("wrap_b1_wea", 64'(mem_wea),        64'h1);
      chk("wrap_b1_din", 64'(mem_din[7:0]),   64'hCA);
`else
      chk("wrap_err", 64'(st_err), 64'd1);
`endif
      step();

      // Reset with a beat still pending.
`ifdef STORE_MISALIGNED_SPLIT_EN
      issue(3'b010, 32'h0000_0101, 32'hA5A5_A5A5);
      step();
`else
      mem_ready = 1'b0;
      issue(3'b010, 32'h0000_0100, 32'hA5A5_A5A5);
`endif
      mem_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      expq.delete();
      samp();
      chk("rst_mid_valid", 64'(mem_valid), 64'd0);
      chk("rst_mid_ready", 64'(st_ready),  64'd1);
      chk("rst_mid_wea",   64'(mem_wea),   64'd0);
      step();

      // Randomized traffic with random back-pressure.
      for (int c = 0; c < 600; c++) begin
         mem_ready = (($urandom % 4) != 0);
         st_valid  = (($urandom % 2) != 0);
         r = int'($urandom % 8);
         st_funct3 = (r < 7) ? 3'(r % 3) : 3'(3 + ($urandom % 5));
         st_adr    = (($urandom % 8) == 0) ? (32'hFFFF_FFFC | 32'($urandom % 4)) : $urandom;
         st_data   = $urandom;
         samp();
         if (st_valid && st_ready)
            model(st_funct3, st_adr, st_data);
         step();
      end
      st_valid  = 1'b0;
      mem_ready = 1'b1;
      n = 0;
      while (expq.size() != 0 && n < 20) begin
         samp();
         step();
         n++;
      end
      chk("drain_empty", 64'(expq.size()), 64'd0);
      samp();
      chk("final_idle", 64'(mem_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
